fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the instruction memory: owns the program counter, drives the memory address, and consumes the combinational 8-bit instruction word. Assembles one-byte and two-byte (opcode + immediate) instructions and presents them to decode through a registered valid/ready output buffer. Supports branch/jump redirect with flush, and a HALT stop.

## Interface
Parameters:
- ADDR_WIDTH, default `INSTMEM_ADDR_WIDTH (8): PC and memory address width.
- WORD_WIDTH, default `INSTMEM_WORDSIZE (8): instruction word width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_addr  out  ADDR_WIDTH  address to instruction memory; always equals pc.
- imem_data  in  WORD_WIDTH  combinational read data from instruction memory.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_WIDTH  target address.
- instr_valid  out  1  output buffer holds an instruction.
- dec_ready  in  1  decode accepts the instruction this cycle.
- instr_op  out  WORD_WIDTH  opcode byte.
- instr_imm  out  WORD_WIDTH  immediate byte; 0 for one-byte instructions.
- instr_pc  out  ADDR_WIDTH  address of the opcode byte.
- halted  out  1  fetch stopped by HALT.

## Operation
- Reset values: pc=0, state=S_OP, instr_valid=0, instr_op=0, instr_imm=0, instr_pc=0, halted=0, op_hold=0.
- Opcode bit 7 set (`OP_LONG_BIT) = two-byte instruction; immediate at pc+1. Opcode `OP_HALT (8'h7F) = one-byte HALT.
- can_load = !instr_valid || dec_ready. Handshake completes when instr_valid && dec_ready.
- States:
  - S_OP: if imem_data is long: op_hold<=imem_data, op_pc<=pc, pc<=pc+1, go S_IMM (happens regardless of can_load). Else if can_load: load buffer {imem_data, 0, pc}, instr_valid<=1, pc<=pc+1; if imem_data==`OP_HALT go S_HALT, halted<=1. Else hold.
  - S_IMM: if can_load: load buffer {op_hold, imem_data, op_pc}, instr_valid<=1, pc<=pc+1, go S_OP. Else hold.
  - S_HALT: pc frozen; buffer drains normally via dec_ready; no new loads.
- When can_load and no new load occurs, instr_valid<=0 on handshake.
- redirect_valid has highest priority over all state actions: pc<=redirect_pc, state<=S_OP, instr_valid<=0 (unaccepted buffered instruction dropped; one accepted in the same cycle counts as delivered), op_hold discarded, halted<=0.
- PC arithmetic modulo 2^ADDR_WIDTH: pc=255 increments to 0; a long opcode at the last address takes its immediate from address 0.

## Timing
- Fetch is combinational address -> data within one cycle; buffer registered, so instr_valid rises the edge after the opcode (short) or immediate (long) is sampled.
- Throughput with dec_ready=1: one short instruction per cycle; one long instruction per two cycles.
- Redirect asserted in cycle N: target fetched in cycle N+1, first target instruction valid from edge ending N+1 (short) or N+2 (long).
- Backpressure: buffer outputs and pc stable while instr_valid && !dec_ready.
- rst_n low mid-operation clears all state immediately, independent of clk.

## Structure
- constants.v (shared): `INSTMEM_ADDR_WIDTH, `INSTMEM_WORDSIZE, new `OP_LONG_BIT, `OP_HALT, state encodings `FS_OP/`FS_IMM/`FS_HALT.
- Single module, no sub-module; instruction memory instantiated beside it at top level, imem_addr -> Address, IOut -> imem_data.

## Test plan
- Program 01,02,03, dec_ready=1 -> instr_op 01,02,03 on three consecutive cycles, instr_pc 0,1,2, instr_imm 0.
- Program 85,3C,04 -> {op=85,imm=3C,pc=0} valid once, then {04,00,pc=2}; no bubble accepted as instruction.
- Hold dec_ready=0 for 4 cycles with short instruction buffered -> outputs and imem_addr stable; release -> next instruction follows one cycle later.
- Redirect to 0x20 while instr_valid=1, dec_ready=0 -> buffer dropped, next valid instr_pc=0x20.
- Program 01,7F,05 -> 01 then 7F delivered, halted=1, pc frozen at 2, 05 never delivered; redirect to 0 clears halted and restarts.
- pc=255 holding 90, address 0 holding AA -> {op=90,imm=AA,pc=255}, pc wraps to 1; assert rst_n low mid-S_IMM -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: memory geometry, opcode classes and fetch states.
package fetch_unit_pkg;

    localparam int INSTMEM_ADDR_WIDTH = 8;
    localparam int INSTMEM_WORDSIZE   = 8;

    // Opcodes with this bit set carry an immediate byte in the following word.
    localparam int         OP_LONG_BIT = 7;
    localparam logic [7:0] OP_HALT     = 8'h7F;

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_IMM  = 2'd1,
        S_HALT = 2'd2
    } fetchState_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, assembles 1/2-byte instructions and hands them
// to decode through a registered valid/ready buffer, with redirect flush and HALT.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = INSTMEM_ADDR_WIDTH,
    parameter int WORD_WIDTH = INSTMEM_WORDSIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [WORD_WIDTH-1:0] imem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  dec_ready,
    output logic [WORD_WIDTH-1:0] instr_op,
    output logic [WORD_WIDTH-1:0] instr_imm,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  halted
);

    fetchState_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  valid_q, valid_d;
    logic [WORD_WIDTH-1:0] op_q, op_d;
    logic [WORD_WIDTH-1:0] imm_q, imm_d;
    logic [ADDR_WIDTH-1:0] instrPc_q, instrPc_d;
    logic                  halted_q, halted_d;
    logic [WORD_WIDTH-1:0] opHold_q, opHold_d;
    logic [ADDR_WIDTH-1:0] opPc_q, opPc_d;

    logic canLoad;
    logic isLong;
    logic isHalt;

    assign canLoad = !valid_q || dec_ready;
    assign isLong  = imem_data[OP_LONG_BIT];
    assign isHalt  = (imem_data == WORD_WIDTH'(OP_HALT));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        op_d      = op_q;
        imm_d     = imm_q;
        instrPc_d = instrPc_q;
        halted_d  = halted_q;
        opHold_d  = opHold_q;
        opPc_d    = opPc_q;

        if (redirect_valid) begin
            // Redirect wins outright; an instruction accepted this cycle is already delivered.
            pc_d     = redirect_pc;
            state_d  = S_OP;
            valid_d  = 1'b0;
            opHold_d = '0;
            halted_d = 1'b0;
        end else begin
            if (valid_q && dec_ready) begin
                valid_d = 1'b0;
            end
            unique case (state_q)
                S_OP: begin
                    // A long opcode is captured even under backpressure; the load waits in S_IMM.
                    if (isLong) begin
                        opHold_d = imem_data;
                        opPc_d   = pc_q;
                        pc_d     = pc_q + ADDR_WIDTH'(1);
                        state_d  = S_IMM;
                    end else if (canLoad) begin
                        op_d      = imem_data;
                        imm_d     = '0;
                        instrPc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + ADDR_WIDTH'(1);
                        if (isHalt) begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                        end
                    end
                end
                S_IMM: begin
                    if (canLoad) begin
                        op_d      = opHold_q;
                        imm_d     = imem_data;
                        instrPc_d = opPc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + ADDR_WIDTH'(1);
                        state_d   = S_OP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_OP;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            op_q      <= '0;
            imm_q     <= '0;
            instrPc_q <= '0;
            halted_q  <= 1'b0;
            opHold_q  <= '0;
            opPc_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            op_q      <= op_d;
            imm_q     <= imm_d;
            instrPc_q <= instrPc_d;
            halted_q  <= halted_d;
            opHold_q  <= opHold_d;
            opPc_q    <= opPc_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr_op    = op_q;
    assign instr_imm   = imm_q;
    assign instr_pc    = instrPc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory model.
module tb_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] imemAddr;
    logic [7:0] imemData;
    logic       redirectValid;
    logic [7:0] redirectPc;
    logic       instrValid;
    logic       decReady;
    logic [7:0] instrOp;
    logic [7:0] instrImm;
    logic [7:0] instrPc;
    logic       halted;

    logic [7:0] mem [256];
    int checks;
    int failures;

    assign imemData = mem[imemAddr];

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imemAddr),
        .imem_data     (imemData),
        .redirect_valid(redirectValid),
        .redirect_pc   (redirectPc),
        .instr_valid   (instrValid),
        .dec_ready     (decReady),
        .instr_op      (instrOp),
        .instr_imm     (instrImm),
        .instr_pc      (instrPc),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Holds reset across two falling edges, checks the reset state, releases at a falling edge.
    task automatic doReset();
        rst_n = 1'b0;
        redirectValid = 1'b0;
        redirectPc = 8'h00;
        decReady = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", instrValid); end
        checks++; if (imemAddr !== 8'h00) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=00", imemAddr); end
        checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted got=%b exp=0", halted); end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clearMem();
        doReset();
        checks++; if (instrOp !== 8'h00) begin failures++; $display("[TB] FAIL reset_op got=%h exp=00", instrOp); end
        checks++; if (instrImm !== 8'h00) begin failures++; $display("[TB] FAIL reset_imm got=%h exp=00", instrImm); end
        checks++; if (instrPc !== 8'h00) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=00", instrPc); end
    endtask

    task automatic test_short_stream();
        clearMem();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        doReset();
        decReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (instrValid !== 1'b1) begin failures++; $display("[TB] FAIL short_valid%0d got=%b exp=1", i, instrValid); end
            checks++; if (instrOp !== 8'(i + 1)) begin failures++; $display("[TB] FAIL short_op%0d got=%h exp=%h", i, instrOp, 8'(i + 1)); end
            checks++; if (instrPc !== 8'(i)) begin failures++; $display("[TB] FAIL short_pc%0d got=%h exp=%h", i, instrPc, 8'(i)); end
            checks++; if (instrImm !== 8'h00) begin failures++; $display("[TB] FAIL short_imm%0d got=%h exp=00", i, instrImm); end
        end
    endtask

    task automatic test_long();
        clearMem();
        mem[0] = 8'h85; mem[1] = 8'h3C; mem[2] = 8'h04;
        doReset();
        decReady = 1'b1;
        @(negedge clk);
        checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL long_bubble got=%b exp=0", instrValid); end
        @(negedge clk);
        checks++; if (instrValid !== 1'b1) begin failures++; $display("[TB] FAIL long_valid got=%b exp=1", instrValid); end
        checks++; if (instrOp !== 8'h85) begin failures++; $display("[TB] FAIL long_op got=%h exp=85", instrOp); end
        checks++; if (instrImm !== 8'h3C) begin failures++; $display("[TB] FAIL long_imm got=%h exp=3c", instrImm); end
        checks++; if (instrPc !== 8'h00) begin failures++; $display("[TB] FAIL long_pc got=%h exp=00", instrPc); end
        @(negedge clk);
        checks++; if (instrValid !== 1'b1) begin failures++; $display("[TB] FAIL long_next_valid got=%b exp=1", instrValid); end
        checks++; if (instrOp !== 8'h04) begin failures++; $display("[TB] FAIL long_next_op got=%h exp=04", instrOp); end
        checks++; if (instrImm !== 8'h00) begin failures++; $display("[TB] FAIL long_next_imm got=%h exp=00", instrImm); end
        checks++; if (instrPc !== 8'h02) begin failures++; $display("[TB] FAIL long_next_pc got=%h exp=02", instrPc); end
    endtask

    task automatic test_backpressure();
        clearMem();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        doReset();
        decReady = 1'b0;
        @(negedge clk);
        checks++; if (instrValid !== 1'b1) begin failures++; $display("[TB] FAIL bp_first_valid got=%b exp=1", instrValid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (instrOp !== 8'h01) begin failures++; $display("[TB] FAIL bp_hold_op%0d got=%h exp=01", i, instrOp); end
            checks++; if (imemAddr !== 8'h01) begin failures++; $display("[TB] FAIL bp_hold_addr%0d got=%h exp=01", i, imemAddr); end
            checks++; if (instrValid !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold_valid%0d got=%b exp=1", i, instrValid); end
        end
        decReady = 1'b1;
        @(negedge clk);
        checks++; if (instrOp !== 8'h02) begin failures++; $display("[TB] FAIL bp_release_op got=%h exp=02", instrOp); end
        checks++; if (instrPc !== 8'h01) begin failures++; $display("[TB] FAIL bp_release_pc got=%h exp=01", instrPc); end
    endtask

    task automatic test_redirect();
        clearMem();
        mem[0] = 8'h01; mem[8'h20] = 8'h11;
        doReset();
        decReady = 1'b0;
        @(negedge clk);
        checks++; if (instrValid !== 1'b1) begin failures++; $display("[TB] FAIL redir_pre_valid got=%b exp=1", instrValid); end
        redirectValid = 1'b1;
        redirectPc = 8'h20;
        @(negedge clk);
        checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL redir_drop got=%b exp=0", instrValid); end
        checks++; if (imemAddr !== 8'h20) begin failures++; $display("[TB] FAIL redir_addr got=%h exp=20", imemAddr); end
        redirectValid = 1'b0;
        decReady = 1'b1;
        @(negedge clk);
        checks++; if (instrValid !== 1'b1) begin failures++; $display("[TB] FAIL redir_tgt_valid got=%b exp=1", instrValid); end
        checks++; if (instrOp !== 8'h11) begin failures++; $display("[TB] FAIL redir_tgt_op got=%h exp=11", instrOp); end
        checks++; if (instrPc !== 8'h20) begin failures++; $display("[TB] FAIL redir_tgt_pc got=%h exp=20", instrPc); end
    endtask

    task automatic test_halt();
        clearMem();
        mem[0] = 8'h01; mem[1] = 8'h7F; mem[2] = 8'h05;
        doReset();
        decReady = 1'b1;
        @(negedge clk);
        checks++; if (instrOp !== 8'h01) begin failures++; $display("[TB] FAIL halt_op0 got=%h exp=01", instrOp); end
        @(negedge clk);
        checks++; if (instrOp !== 8'h7F) begin failures++; $display("[TB] FAIL halt_op1 got=%h exp=7f", instrOp); end
        checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL halt_flag got=%b exp=1", halted); end
        checks++; if (imemAddr !== 8'h02) begin failures++; $display("[TB] FAIL halt_addr got=%h exp=02", imemAddr); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL halt_no_fetch%0d got=%b exp=0", i, instrValid); end
            checks++; if (imemAddr !== 8'h02) begin failures++; $display("[TB] FAIL halt_frozen%0d got=%h exp=02", i, imemAddr); end
        end
        redirectValid = 1'b1;
        redirectPc = 8'h00;
        @(negedge clk);
        checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL halt_clear got=%b exp=0", halted); end
        checks++; if (imemAddr !== 8'h00) begin failures++; $display("[TB] FAIL halt_restart_addr got=%h exp=00", imemAddr); end
        redirectValid = 1'b0;
        @(negedge clk);
        checks++; if (instrValid !== 1'b1) begin failures++; $display("[TB] FAIL halt_restart_valid got=%b exp=1", instrValid); end
        checks++; if (instrOp !== 8'h01) begin failures++; $display("[TB] FAIL halt_restart_op got=%h exp=01", instrOp); end
    endtask

    // Long opcode at the last address, then async reset while a second long opcode waits in S_IMM.
    task automatic test_wrap_and_async_reset();
        clearMem();
        mem[8'hFF] = 8'h90; mem[0] = 8'hAA; mem[1] = 8'hC1;
        doReset();
        decReady = 1'b1;
        redirectValid = 1'b1;
        redirectPc = 8'hFF;
        @(negedge clk);
        checks++; if (imemAddr !== 8'hFF) begin failures++; $display("[TB] FAIL wrap_start_addr got=%h exp=ff", imemAddr); end
        redirectValid = 1'b0;
        @(negedge clk);
        checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL wrap_bubble got=%b exp=0", instrValid); end
        checks++; if (imemAddr !== 8'h00) begin failures++; $display("[TB] FAIL wrap_addr0 got=%h exp=00", imemAddr); end
        @(negedge clk);
        checks++; if (instrOp !== 8'h90) begin failures++; $display("[TB] FAIL wrap_op got=%h exp=90", instrOp); end
        checks++; if (instrImm !== 8'hAA) begin failures++; $display("[TB] FAIL wrap_imm got=%h exp=aa", instrImm); end
        checks++; if (instrPc !== 8'hFF) begin failures++; $display("[TB] FAIL wrap_pc got=%h exp=ff", instrPc); end
        checks++; if (imemAddr !== 8'h01) begin failures++; $display("[TB] FAIL wrap_addr1 got=%h exp=01", imemAddr); end
        decReady = 1'b0;
        @(negedge clk);
        checks++; if (imemAddr !== 8'h02) begin failures++; $display("[TB] FAIL imm_wait_addr got=%h exp=02", imemAddr); end
        checks++; if (instrValid !== 1'b1) begin failures++; $display("[TB] FAIL imm_wait_valid got=%b exp=1", instrValid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL async_valid got=%b exp=0", instrValid); end
        checks++; if (instrOp !== 8'h00) begin failures++; $display("[TB] FAIL async_op got=%h exp=00", instrOp); end
        checks++; if (instrImm !== 8'h00) begin failures++; $display("[TB] FAIL async_imm got=%h exp=00", instrImm); end
        checks++; if (instrPc !== 8'h00) begin failures++; $display("[TB] FAIL async_pc got=%h exp=00", instrPc); end
        checks++; if (imemAddr !== 8'h00) begin failures++; $display("[TB] FAIL async_addr got=%h exp=00", imemAddr); end
        checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL async_halted got=%b exp=0", halted); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        decReady = 1'b0;
        redirectValid = 1'b0;
        redirectPc = 8'h00;
        test_reset();
        test_short_stream();
        test_long();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
